// File: rtl/output_pulser_if.sv
// output_pulser_if
//   Request/status bundle for output_pulser.
//   master : drives req, observes the pin and status (CPU / peripheral glue side)
//   slave  : samples req, drives the pin and status (output_pulser side)
//   Signals:
//     req      - single-cycle pulse request, one request per high cycle
//     pin_out  - registered pin drive
//     busy     - a pulse (high phase or low gap) is in flight
//     pending  - queued request count
//     done     - one-cycle strobe after each low gap completes
//     dropped  - sticky overflow flag
interface output_pulser_if #(
   parameter int PENDING_SIZE = 4
);
   logic                    req;
   logic                    pin_out;
   logic                    busy;
   logic [PENDING_SIZE-1:0] pending;
   logic                    done;
   logic                    dropped;

   modport master (
      output req,
      input  pin_out, busy, pending, done, dropped
   );

   modport slave (
      input  req,
      output pin_out, busy, pending, done, dropped
   );
endinterface

// File: rtl/output_pulser.sv
// output_pulser
//   Timed pulse generator for an output pin. Each accepted request gives one
//   pin pulse of ON_TIME cycles high followed by OFF_TIME cycles low.
//   Requests arriving while a pulse is in flight are counted in `pending`
//   and replayed back-to-back; overflow of that counter sets `dropped`.
//   Ports:
//     clk    - clock
//     reset  - synchronous, active-high reset
//     bus    - output_pulser_if.slave (req in; pin_out/busy/pending/done/dropped out)
//   Parameters:
//     COUNTER_SIZE - phase timer width
//     ON_TIME      - high time in cycles, 1..2^COUNTER_SIZE-1
//     OFF_TIME     - low gap in cycles,  1..2^COUNTER_SIZE-1
//     PENDING_SIZE - pending-request counter width (must match the interface)
module output_pulser #(
   parameter int COUNTER_SIZE = 8,
   parameter int ON_TIME      = 255,
   parameter int OFF_TIME     = 255,
   parameter int PENDING_SIZE = 4
) (
   input  logic              clk,
   input  logic              reset,
   output_pulser_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   // Terminal timer values for each phase; the timer restarts at 0 on entry.
   localparam logic [COUNTER_SIZE-1:0] ON_LAST  = COUNTER_SIZE'(ON_TIME - 1);
   localparam logic [COUNTER_SIZE-1:0] OFF_LAST = COUNTER_SIZE'(OFF_TIME - 1);
   localparam logic [PENDING_SIZE-1:0] PEND_MAX = '1;

   state_t                  state;
   logic [COUNTER_SIZE-1:0] timer;
   logic                    pin_q;
   logic                    busy_q;
   logic [PENDING_SIZE-1:0] pend_q;
   logic                    done_q;
   logic                    drop_q;

   logic                    req;
   logic                    off_exit;

   assign req      = bus.req;
   // Last cycle of the low gap: the only point where a queued request is replayed.
   assign off_exit = (state == S_OFF) && (timer == OFF_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         timer  <= '0;
         pin_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
         pend_q <= '0;
      end else begin
         done_q <= 1'b0;

         // Requests during a pulse (outside the exit cycle) are queued.
         // A request that finds the counter full is lost and flagged.
         if ((state != S_IDLE) && !off_exit && req) begin
            if (pend_q == PEND_MAX) drop_q <= 1'b1;
            else                    pend_q <= pend_q + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (req) begin
                  state  <= S_ON;
                  timer  <= '0;
                  pin_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end

            S_ON: begin
               if (timer == ON_LAST) begin
                  state <= S_OFF;
                  timer <= '0;
                  pin_q <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_OFF: begin
               if (off_exit) begin
                  done_q <= 1'b1;
                  if ((pend_q != '0) || req) begin
                     state <= S_ON;
                     timer <= '0;
                     pin_q <= 1'b1;
                     // A same-cycle request either replaces the queued one
                     // (net zero) or is consumed directly when the queue is
                     // empty; only a queue-only restart drains the counter.
                     if ((pend_q != '0) && !req) pend_q <= pend_q - 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               state  <= S_IDLE;
               timer  <= '0;
               pin_q  <= 1'b0;
               busy_q <= 1'b0;
               pend_q <= '0;
            end
         endcase
      end
   end

   assign bus.pin_out = pin_q;
   assign bus.busy    = busy_q;
   assign bus.pending = pend_q;
   assign bus.done    = done_q;
   assign bus.dropped = drop_q;

endmodule

// File: tb/tb_output_pulser.sv
module tb_output_pulser;
   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PW  = 2;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Packed observation: {pin_out, busy, done, dropped, pending[1:0]}
   logic [5:0] sb[$];
   logic [5:0] e;
   logic [5:0] o;

   output_pulser_if #(.PENDING_SIZE(PW)) bus ();

   output_pulser #(
      .COUNTER_SIZE(8),
      .ON_TIME     (ON),
      .OFF_TIME    (OFF),
      .PENDING_SIZE(PW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got running required finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [5:0] obs();
      return {bus.pin_out, bus.busy, bus.done, bus.dropped, bus.pending};
   endfunction

   function automatic logic [5:0] ex(bit pin, bit bsy, bit dn, bit drp, int pend);
      logic [1:0] p;
      p = pend[1:0];
      return {pin, bsy, dn, drp, p};
   endfunction

   function automatic bit in_pulse(int c, int s);
      return (c >= s) && (c < s + ON);
   endfunction

   task automatic do_reset();
      reset   = 1'b1;
      bus.req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 9; c++) sb.push_back(ex(0, 0, 0, 0, 0));
      for (int c = 0; c < 9; c++) begin
         e = sb.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset c=%0d got %b required %b", c, o, e);
         end
         reset   = (c < 2);
         bus.req = (c < 2) ? c[0] : 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 0; c < 9; c++)
         sb.push_back(ex(in_pulse(c, 1), c >= 1 && c <= 5, c == 6, 0, 0));
      for (int c = 0; c < 9; c++) begin
         e = sb.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL single c=%0d got %b required %b", c, o, e);
         end
         bus.req = (c == 0);
         @(negedge clk);
      end
   endtask

   task automatic test_queue();
      int p;
      do_reset();
      for (int c = 0; c < 19; c++) begin
         p = (c == 2) ? 1 : (c >= 3 && c <= 5) ? 2 : (c >= 6 && c <= 10) ? 1 : 0;
         sb.push_back(ex(in_pulse(c, 1) || in_pulse(c, 6) || in_pulse(c, 11),
                         c >= 1 && c <= 15, c == 6 || c == 11 || c == 16, 0, p));
      end
      for (int c = 0; c < 19; c++) begin
         e = sb.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL queue c=%0d got %b required %b", c, o, e);
         end
         bus.req = (c <= 2);
         @(negedge clk);
      end
   endtask

   task automatic test_saturate();
      int p;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         p = (c == 2) ? 1 : (c == 3) ? 2 : (c == 4 || c == 5) ? 3 :
             (c >= 6 && c <= 10) ? 2 : (c >= 11 && c <= 15) ? 1 : 0;
         sb.push_back(ex(in_pulse(c, 1) || in_pulse(c, 6) || in_pulse(c, 11) || in_pulse(c, 16),
                         c >= 1 && c <= 20, c == 6 || c == 11 || c == 16 || c == 21,
                         c >= 5, p));
      end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL saturate c=%0d got %b required %b", c, o, e);
         end
         bus.req = (c <= 4);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 14; c++)
         sb.push_back(ex(in_pulse(c, 1) || in_pulse(c, 6), c >= 1 && c <= 10,
                         c == 6 || c == 11, 0, 0));
      for (int c = 0; c < 14; c++) begin
         e = sb.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back c=%0d got %b required %b", c, o, e);
         end
         bus.req = (c == 0 || c == 5);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 11; c++)
         sb.push_back(ex(c == 1 || c == 2, c == 1 || c == 2, 0, 0, 0));
      for (int c = 0; c < 11; c++) begin
         e = sb.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid c=%0d got %b required %b", c, o, e);
         end
         bus.req = (c == 0 || c == 2);
         reset   = (c == 2);
         @(negedge clk);
      end
   endtask

   initial begin
      reset   = 1'b1;
      bus.req = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_queue();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain got %0d required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
